// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

    localparam int SIPO_DATA_W = 8;

    // Keep the counter at least one bit wide even for degenerate word sizes.
    function automatic int sipo_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sipo.sv
// Deserializer: collects MSB-first serial bits into DATA_W-bit words and
// presents each completed word with a registered one-cycle strobe.
module sipo
    import sipo_pkg::*;
#(
    parameter int DATA_W = SIPO_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_serial_i,
    input  logic              valid_serial_i,
    output logic [DATA_W-1:0] data_parallel_o,
    output logic              byte_ready_o
);

    localparam int CNT_W = sipo_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              word_done_q, word_done_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] shreg_next;

    assign shreg_next = {shreg_q[DATA_W-2:0], data_serial_i};

    always_comb begin
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        word_done_d = 1'b0;
        data_d      = data_q;
        ready_d     = 1'b0;

        if (valid_serial_i) begin
            shreg_d = shreg_next;
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                word_done_d = 1'b1;
                // Snapshot here so an immediate next-word MSB can't corrupt it.
                hold_d      = shreg_next;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (word_done_q) begin
            data_d  = hold_q;
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
            data_q      <= '0;
            ready_q     <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
        end
    end

    assign data_parallel_o = data_q;
    assign byte_ready_o    = ready_q;

endmodule

// File: tb/tb_sipo.sv
// Scoreboard bench for sipo: stimulus pushes expected words with their due
// cycle, a negedge monitor pops and compares on every strobe.
module tb_sipo;

    logic       clk;
    logic       rst_n;
    logic       data_serial_i;
    logic       valid_serial_i;
    logic [7:0] data_parallel_o;
    logic       byte_ready_o;

    sipo #(.DATA_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_serial_i  (data_serial_i),
        .valid_serial_i (valid_serial_i),
        .data_parallel_o(data_parallel_o),
        .byte_ready_o   (byte_ready_o)
    );

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] m_sh = '0;
    int         m_cnt = 0;
    logic       prev_rdy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expected word at its due cycle.
    always @(negedge clk) begin
        if (byte_ready_o) begin
            checks = checks + 1;
            if (prev_rdy) begin
                errors = errors + 1;
                $display("FAIL strobe_width: byte_ready_o high two cycles in a row at cycle %0d", cyc);
            end
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_strobe: got data %h at cycle %0d, none expected", data_parallel_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (data_parallel_o !== e.data || cyc != e.due) begin
                    errors = errors + 1;
                    $display("FAIL word: got %h at cycle %0d, want %h at cycle %0d",
                             data_parallel_o, cyc, e.data, e.due);
                end
            end
        end
        prev_rdy = byte_ready_o;
    end

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Drive one valid bit; the model predicts the strobe one cycle after the sampling edge.
    task automatic send_bit(input logic b);
        exp_t e;
        data_serial_i  = b;
        valid_serial_i = 1'b1;
        @(posedge clk);
        #1;
        valid_serial_i = 1'b0;
        data_serial_i  = 1'b0;
        m_sh  = {m_sh[6:0], b};
        m_cnt = m_cnt + 1;
        if (m_cnt == 8) begin
            e.data = m_sh;
            e.due  = cyc + 1;
            sb.push_back(e);
            m_cnt = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        valid_serial_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        m_cnt = 0;
        m_sh  = '0;
    endtask

    initial begin
        logic [7:0] rb;
        rst_n          = 1'b0;
        data_serial_i  = 1'b0;
        valid_serial_i = 1'b0;
        do_reset(3);
        check("reset_outputs", {byte_ready_o, data_parallel_o}, 9'h000);
        rst_n = 1'b1;
        idle(2);

        // Alternating pattern, then confirm the strobe has dropped.
        send_byte(8'b10101010);
        idle(3);
        check("aa_hold", {byte_ready_o, data_parallel_o}, {1'b0, 8'hAA});

        // Idle cycles in mid-word neither shift nor count.
        send_bit(1); send_bit(1); send_bit(1); send_bit(1);
        idle(2);
        send_bit(0); send_bit(0); send_bit(0); send_bit(0);
        idle(3);
        check("gap_word", {byte_ready_o, data_parallel_o}, {1'b0, 8'hF0});

        // Partial word discarded by reset.
        send_bit(1); send_bit(0);
        do_reset(2);
        check("midword_reset", {byte_ready_o, data_parallel_o}, 9'h000);
        rst_n = 1'b1;
        idle(1);
        send_byte(8'h3C);
        idle(3);
        check("post_reset_word", {byte_ready_o, data_parallel_o}, {1'b0, 8'h3C});

        // Back-to-back words; output must hold the first while the second streams.
        send_byte(8'hA5);
        send_bit(0); send_bit(1); send_bit(0); send_bit(1);
        check("b2b_hold_mid", {byte_ready_o, data_parallel_o}, {1'b0, 8'hA5});
        send_bit(1); send_bit(0); send_bit(1);
        check("b2b_hold_late", {byte_ready_o, data_parallel_o}, {1'b0, 8'hA5});
        send_bit(0);
        idle(3);
        check("b2b_second", {byte_ready_o, data_parallel_o}, {1'b0, 8'h5A});

        // Seven bits then a long idle: any strobe here is flagged by the monitor.
        send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        send_bit(0); send_bit(1); send_bit(1);
        idle(20);
        check("no_early_strobe", {1'b0, data_parallel_o}, {1'b0, 8'h5A});
        send_bit(1);
        idle(3);
        check("late_eighth_bit", {byte_ready_o, data_parallel_o}, {1'b0, 8'h67});

        // Random bytes with random inter-bit gaps against the MSB-first model.
        for (int n = 0; n < 100; n++) begin
            rb = 8'($urandom_range(0, 255));
            for (int i = 7; i >= 0; i--) begin
                send_bit(rb[i]);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(4);

        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL missing_strobes: %0d expected words never strobed, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
